// File: rtl/hex_capture_pkg.sv
// Shared constants and helpers for the hex capture bank: segment patterns
// and a constant-foldable ceil(log2) used for port widths.
package hex_capture_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment patterns, bit0 = a ... bit6 = g, indexed by nibble value.
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low 7-segment decoder.
module hex7seg
    import hex_capture_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup of the segment pattern for one hex digit.
    always_comb begin
        seg = SEG_LUT[nibble];
    end

endmodule

// File: rtl/hex_capture_bank.sv
// Circular history of button-triggered snapshots of a switch word, with the
// live word and one selected snapshot shown on 7-segment digit groups.
module hex_capture_bank
    import hex_capture_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    localparam int NDIG  = WIDTH / 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_n,
    input  logic              clear,
    input  logic              mode_wrap,
    input  logic [WIDTH-1:0]  din,
    input  logic [PTR_W-1:0]  sel,
    output logic [7*NDIG-1:0] hex_live,
    output logic [7*NDIG-1:0] hex_stored,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              overflow
);

    localparam int CMP_W = PTR_W + CNT_W;
    localparam int IDX_W = PTR_W + 2;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   edge_r;
    logic                   load_pulse_s;
    logic [WIDTH-1:0]       mem_r [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_r;
    logic [PTR_W-1:0]       wr_ptr_next_s;
    logic [CNT_W-1:0]       count_r;
    logic                   full_r;
    logic                   overflow_r;
    logic [IDX_W-1:0]       rd_sum_s;
    logic [PTR_W-1:0]       rd_idx_s;
    logic                   rd_valid_s;
    logic [WIDTH-1:0]       rd_word_s;
    logic [7*NDIG-1:0]      live_seg_s;
    logic [7*NDIG-1:0]      stored_seg_s;
    logic [7*NDIG-1:0]      hex_live_r;
    logic [7*NDIG-1:0]      hex_stored_r;

    // Synchroniser chain plus the edge flop holding the previous synchronised level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_r <= '0;
            edge_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], load_n};
            edge_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign load_pulse_s = edge_r & ~sync_r[SYNC_STAGES-1];

    // Pointer wrap uses an explicit compare so non-power-of-2 depths stay in range.
    always_comb begin
        if (wr_ptr_r == PTR_W'(DEPTH - 1)) begin
            wr_ptr_next_s = '0;
        end else begin
            wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
        end
    end

    // History storage, write pointer and status flags; clear beats a same-cycle load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (clear) begin
            wr_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else if (load_pulse_s) begin
            if (!full_r) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_next_s;
                count_r         <= count_r + CNT_W'(1);
                full_r          <= (count_r == CNT_W'(DEPTH - 1));
            end else if (mode_wrap) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_next_s;
            end else begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Age-to-slot translation: newest entry sits just behind the write pointer.
    always_comb begin
        rd_sum_s = IDX_W'(wr_ptr_r) + IDX_W'(DEPTH - 1) - IDX_W'(sel);
        if (rd_sum_s >= IDX_W'(DEPTH)) begin
            rd_idx_s = PTR_W'(rd_sum_s - IDX_W'(DEPTH));
        end else begin
            rd_idx_s = PTR_W'(rd_sum_s);
        end
        rd_valid_s = CMP_W'(sel) < CMP_W'(count_r);
        if (rd_valid_s) begin
            rd_word_s = mem_r[rd_idx_s];
        end else begin
            rd_word_s = '0;
        end
    end

    for (genvar k = 0; k < NDIG; k++) begin : g_digit
        hex7seg u_live (
            .nibble (din[4*k +: 4]),
            .seg    (live_seg_s[7*k +: 7])
        );
        hex7seg u_stored (
            .nibble (rd_word_s[4*k +: 4]),
            .seg    (stored_seg_s[7*k +: 7])
        );
    end

    // Display registers; slots beyond the valid count show blank digits.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex_live_r   <= '1;
            hex_stored_r <= '1;
        end else begin
            hex_live_r   <= live_seg_s;
            hex_stored_r <= rd_valid_s ? stored_seg_s : {NDIG{SEG_BLANK}};
        end
    end

    assign hex_live   = hex_live_r;
    assign hex_stored = hex_stored_r;
    assign count      = count_r;
    assign full       = full_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_hex_capture_bank.sv
// Bench for hex_capture_bank: a 16-bit/depth-4 and an 8-bit/depth-3 instance
// share stimulus and are checked every cycle against a newest-first history model.
module tb_hex_capture_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_n;
    logic        clear;
    logic        mode_wrap;
    logic [15:0] din;
    logic [1:0]  sel;

    logic [27:0] hex_live0, hex_stored0;
    logic [2:0]  count0;
    logic        full0, overflow0;
    logic [13:0] hex_live1, hex_stored1;
    logic [1:0]  count1;
    logic        full1, overflow1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hex_capture_bank #(.WIDTH(16), .DEPTH(4), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset(reset), .load_n(load_n), .clear(clear), .mode_wrap(mode_wrap),
        .din(din), .sel(sel), .hex_live(hex_live0), .hex_stored(hex_stored0),
        .count(count0), .full(full0), .overflow(overflow0)
    );

    hex_capture_bank #(.WIDTH(8), .DEPTH(3), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .load_n(load_n), .clear(clear), .mode_wrap(mode_wrap),
        .din(din[7:0]), .sel(sel), .hex_live(hex_live1), .hex_stored(hex_stored1),
        .count(count1), .full(full1), .overflow(overflow1)
    );

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h18;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic [27:0] seg16(input logic [15:0] w);
        return {seg7(w[15:12]), seg7(w[11:8]), seg7(w[7:4]), seg7(w[3:0])};
    endfunction

    function automatic logic [13:0] seg8(input logic [7:0] w);
        return {seg7(w[7:4]), seg7(w[3:0])};
    endfunction

    function automatic int depth_of(input int i);
        return (i == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: history kept newest-first per instance; load_n samples from past edges give the pulse.
    logic [15:0] hist [2][4];
    int          hsize [2];
    bit          ovf_m [2];
    logic [27:0] exp_live0, exp_stored0;
    logic [13:0] exp_live1, exp_stored1;
    bit          s_m1, s_m2, s_m3;
    bit          model_on = 1'b0;

    initial begin
        forever begin : mdl
            bit pulse;
            @(posedge clk);
            pulse = s_m3 && !s_m2;
            if (reset) begin
                exp_live0 = '1; exp_stored0 = '1; exp_live1 = '1; exp_stored1 = '1;
                s_m1 = 1'b0; s_m2 = 1'b0; s_m3 = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    hsize[i] = 0;
                    ovf_m[i] = 1'b0;
                end
                model_on = 1'b1;
            end else begin
                exp_live0   = seg16(din);
                exp_live1   = seg8(din[7:0]);
                exp_stored0 = (int'(sel) < hsize[0]) ? seg16(hist[0][sel]) : 28'hFFFFFFF;
                exp_stored1 = (int'(sel) < hsize[1]) ? seg8(hist[1][sel][7:0]) : 14'h3FFF;
                s_m3 = s_m2; s_m2 = s_m1; s_m1 = load_n;
                for (int i = 0; i < 2; i++) begin
                    if (clear) begin
                        hsize[i] = 0;
                        ovf_m[i] = 1'b0;
                    end else if (pulse) begin
                        if (hsize[i] < depth_of(i) || mode_wrap) begin
                            for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
                            hist[i][0] = (i == 0) ? din : {8'h00, din[7:0]};
                            if (hsize[i] < depth_of(i)) hsize[i]++;
                        end else begin
                            ovf_m[i] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("live0",   hex_live0,   exp_live0);
                chk("stored0", hex_stored0, exp_stored0);
                chk("count0",  32'(count0), hsize[0]);
                chk("full0",   32'(full0),  32'(hsize[0] == 4));
                chk("ovf0",    32'(overflow0), 32'(ovf_m[0]));
                chk("live1",   hex_live1,   exp_live1);
                chk("stored1", hex_stored1, exp_stored1);
                chk("count1",  32'(count1), hsize[1]);
                chk("full1",   32'(full1),  32'(hsize[1] == 3));
                chk("ovf1",    32'(overflow1), 32'(ovf_m[1]));
            end
        end
    end

    task automatic press(input logic [15:0] w, input int hold);
        @(negedge clk);
        din = w;
        load_n = 1'b0;
        repeat (hold) @(negedge clk);
        load_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; load_n = 1'b1; clear = 1'b0; mode_wrap = 1'b0; din = 16'h0000; sel = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        din = 16'h1234;
        @(negedge clk);
        chk("t1_live",   hex_live0,   {7'h79, 7'h24, 7'h30, 7'h19});
        chk("t1_stored", hex_stored0, 28'hFFFFFFF);
        chk("t1_count",  32'(count0), 32'd0);
        chk("t1_full",   32'(full0),  32'd0);

        press(16'hA5C3, 10);
        chk("t2_count",   32'(count0), 32'd1);
        chk("t2_stored",  hex_stored0, {7'h08, 7'h12, 7'h46, 7'h30});
        chk("t2_stored1", hex_stored1, {7'h46, 7'h30});

        do_clear();
        mode_wrap = 1'b1;
        for (int v = 1; v <= 5; v++) press(16'(v), 4);
        chk("t3_count", 32'(count0), 32'd4);
        chk("t3_full",  32'(full0),  32'd1);
        chk("t3_ovf",   32'(overflow0), 32'd0);
        chk("t3_sel0",  hex_stored0, {7'h40, 7'h40, 7'h40, 7'h12});
        sel = 2'd3;
        settle();
        chk("t3_sel3",  hex_stored0, {7'h40, 7'h40, 7'h40, 7'h24});
        sel = 2'd0;

        do_clear();
        mode_wrap = 1'b0;
        for (int v = 1; v <= 5; v++) press(16'(v), 4);
        settle();
        chk("t4_ovf",   32'(overflow0), 32'd1);
        chk("t4_ovf1",  32'(overflow1), 32'd1);
        chk("t4_sel0",  hex_stored0, {7'h40, 7'h40, 7'h40, 7'h19});
        sel = 2'd3;
        settle();
        chk("t4_sel3",  hex_stored0, {7'h40, 7'h40, 7'h40, 7'h79});
        sel = 2'd0;

        do_clear();
        press(16'h0009, 4);
        press(16'h000B, 4);
        sel = 2'd2;
        settle();
        chk("t5_blank", hex_stored0, 28'hFFFFFFF);
        chk("t5_count", 32'(count0), 32'd2);
        sel = 2'd0;
        @(negedge clk);
        din = 16'h00EE;
        load_n = 1'b0;
        repeat (2) @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (3) @(negedge clk);
        load_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_clr_count", 32'(count0), 32'd0);
        chk("t5_clr_ovf",   32'(overflow0), 32'd0);
        chk("t5_clr_blank", hex_stored0, 28'hFFFFFFF);
        press(16'h00D7, 4);
        chk("t5_after",     hex_stored0, {7'h40, 7'h40, 7'h21, 7'h78});

        do_clear();
        mode_wrap = 1'b1;
        for (int v = 1; v <= 7; v++) press(16'(v), 4);
        chk("t6_count1", 32'(count1), 32'd3);
        chk("t6_full1",  32'(full1),  32'd1);
        chk("t6_sel0",   hex_stored1, {7'h40, 7'h78});
        sel = 2'd1;
        settle();
        chk("t6_sel1",   hex_stored1, {7'h40, 7'h02});
        sel = 2'd2;
        settle();
        chk("t6_sel2",   hex_stored1, {7'h40, 7'h12});
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
